// File: rtl/rand_cmp_if.sv
// Handshake and result bus for the four-number sort/sum controller.
// The master loads numbers and observes results; the slave is the controller.
interface rand_cmp_if;
   logic       in_valid;
   logic [3:0] in_number;
   logic       in_ready;
   logic       out_valid;
   logic [4:0] out_number1;
   logic [4:0] out_number2;

   modport master (
      output in_valid, in_number,
      input  in_ready, out_valid, out_number1, out_number2
   );

   modport slave (
      input  in_valid, in_number,
      output in_ready, out_valid, out_number1, out_number2
   );
endinterface

// File: rtl/rand_cmp_ctrl.sv
// Loads four unsigned 4-bit numbers, sorts them descending with a 3-stage
// compare-exchange network (one stage per cycle), then reports the sum of the
// two largest and the sum of the two smallest as a one-cycle result pulse.
module rand_cmp_ctrl #(
   parameter bit HOLD_OUT = 1'b0
) (
   input logic       clk,
   input logic       rst,
   rand_cmp_if.slave bus
);
   localparam int DATA_W = 4;
   localparam int SUM_W  = 5;
   localparam int STAGES = 3;

   typedef enum logic [1:0] {IDLE, LOAD, SORT, OUT} state_t;

   state_t            state, state_nxt;
   logic [1:0]        cnt;
   logic [1:0]        stage;
   logic [DATA_W-1:0] slot     [4];
   logic [DATA_W-1:0] slot_nxt [4];
   logic [SUM_W-1:0]  res1, res2;
   logic              in_ready_c;
   logic              out_valid_c;
   logic              accept;
   logic              last_stage;

   // Compare-exchange: larger value first; equal values keep their order.
   function automatic logic [2*DATA_W-1:0] cx(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
      return (b > a) ? {b, a} : {a, b};
   endfunction

   // Zero-extended add: two 4-bit operands never overflow 5 bits.
   function automatic logic [SUM_W-1:0] add_u(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

   assign accept     = bus.in_valid && in_ready_c;
   assign last_stage = (stage == 2'(STAGES - 1));

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = LOAD;
         LOAD:    if (accept && cnt == 2'd3) state_nxt = SORT;
         SORT:    if (last_stage) state_nxt = OUT;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake and result outputs decoded from the current state.
   always_comb begin
      in_ready_c  = (state == IDLE) || (state == LOAD);
      out_valid_c = (state == OUT);
   end

   assign bus.in_ready    = in_ready_c;
   assign bus.out_valid   = out_valid_c;
   assign bus.out_number1 = (HOLD_OUT || out_valid_c) ? res1 : '0;
   assign bus.out_number2 = (HOLD_OUT || out_valid_c) ? res2 : '0;

   // One sorting-network stage applied to the current slots.
   always_comb begin
      for (int i = 0; i < 4; i++) slot_nxt[i] = slot[i];
      case (stage)
         2'd0: begin
            {slot_nxt[0], slot_nxt[1]} = cx(slot[0], slot[1]);
            {slot_nxt[2], slot_nxt[3]} = cx(slot[2], slot[3]);
         end
         2'd1: begin
            {slot_nxt[0], slot_nxt[2]} = cx(slot[0], slot[2]);
            {slot_nxt[1], slot_nxt[3]} = cx(slot[1], slot[3]);
         end
         default: begin
            {slot_nxt[1], slot_nxt[2]} = cx(slot[1], slot[2]);
         end
      endcase
   end

   // Slot loading, load counter and in-place sorting.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) slot[i] <= '0;
         cnt <= 2'd0;
      end else if (accept) begin
         slot[cnt] <= bus.in_number;
         cnt       <= cnt + 2'd1;
      end else if (state == SORT) begin
         for (int i = 0; i < 4; i++) slot[i] <= slot_nxt[i];
      end
   end

   // Sort stage counter, running only while sorting.
   always_ff @(posedge clk) begin
      if (rst)                stage <= 2'd0;
      else if (state == SORT) stage <= stage + 2'd1;
      else                    stage <= 2'd0;
   end

   // Result registers, captured from the fully sorted slots on the last stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         res1 <= '0;
         res2 <= '0;
      end else if (state == SORT && last_stage) begin
         res1 <= add_u(slot_nxt[0], slot_nxt[1]);
         res2 <= add_u(slot_nxt[2], slot_nxt[3]);
      end
   end
endmodule

// File: tb/tb_rand_cmp_ctrl.sv
// Bench for rand_cmp_ctrl: drives a HOLD_OUT=0 and a HOLD_OUT=1 instance with
// identical stimulus and compares both against a behavioural model.
module tb_rand_cmp_ctrl;
   logic clk;
   logic rst;

   rand_cmp_if i0 ();
   rand_cmp_if i1 ();

   rand_cmp_ctrl #(.HOLD_OUT(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(i0));
   rand_cmp_ctrl #(.HOLD_OUT(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(i1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model state: numbers accepted so far, cycle of next result, last result.
   int q[$];
   int cyc;
   int out_cyc;
   int pend1, pend2;
   int hold1, hold2;
   int seen1, seen2;
   int nvalid;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic compute_result();
      int a[4];
      int t;
      for (int i = 0; i < 4; i++) a[i] = q[i];
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3 - i; j++)
            if (a[j] < a[j+1]) begin
               t = a[j]; a[j] = a[j+1]; a[j+1] = t;
            end
      pend1 = a[0] + a[1];
      pend2 = a[2] + a[3];
   endtask

   // One clock cycle: drive, check outputs against the model, then advance it.
   task automatic step(input bit v, input int n, input bit r);
      bit exp_ready, exp_valid;
      i0.in_valid = v;  i0.in_number = 4'(n);
      i1.in_valid = v;  i1.in_number = 4'(n);
      rst = r;
      @(negedge clk);
      exp_ready = (out_cyc < 0) || (cyc > out_cyc);
      exp_valid = (cyc == out_cyc);
      if (exp_valid) begin
         hold1 = pend1;
         hold2 = pend2;
      end
      chk("ready0", 8'(i0.in_ready), 8'(exp_ready));
      chk("ready1", 8'(i1.in_ready), 8'(exp_ready));
      chk("valid0", 8'(i0.out_valid), 8'(exp_valid));
      chk("valid1", 8'(i1.out_valid), 8'(exp_valid));
      chk("n1_h0", 8'(i0.out_number1), 8'(exp_valid ? pend1 : 0));
      chk("n2_h0", 8'(i0.out_number2), 8'(exp_valid ? pend2 : 0));
      chk("n1_h1", 8'(i1.out_number1), 8'(hold1));
      chk("n2_h1", 8'(i1.out_number2), 8'(hold2));
      if (i0.out_valid === 1'b1) begin
         seen1 = int'(i0.out_number1);
         seen2 = int'(i0.out_number2);
         nvalid++;
      end
      @(posedge clk);
      if (r) begin
         q.delete();
         out_cyc = -1;
         hold1 = 0;
         hold2 = 0;
      end else if (v && exp_ready) begin
         q.push_back(n);
         if (q.size() == 4) begin
            compute_result();
            q.delete();
            out_cyc = cyc + 4;
         end
      end
      cyc++;
      #1;
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) step(1'b0, 0, 1'b0);
   endtask

   task automatic load4(input int a, input int b, input int c, input int d);
      step(1'b1, a, 1'b0);
      step(1'b1, b, 1'b0);
      step(1'b1, c, 1'b0);
      step(1'b1, d, 1'b0);
   endtask

   initial begin
      cyc = 0; out_cyc = -1; pend1 = 0; pend2 = 0; hold1 = 0; hold2 = 0;
      seen1 = -1; seen2 = -1; nvalid = 0;
      rst = 1'b1;
      i0.in_valid = 1'b1; i0.in_number = 4'd9;
      i1.in_valid = 1'b1; i1.in_number = 4'd9;
      repeat (2) @(posedge clk);
      #1;
      // Reset state, with a number presented during reset.
      chk("rst_ready", 8'(i0.in_ready), 8'd1);
      chk("rst_valid", 8'(i0.out_valid), 8'd0);
      chk("rst_n1_h0", 8'(i0.out_number1), 8'd0);
      chk("rst_n2_h0", 8'(i0.out_number2), 8'd0);
      chk("rst_n1_h1", 8'(i1.out_number1), 8'd0);
      chk("rst_n2_h1", 8'(i1.out_number2), 8'd0);
      step(1'b0, 0, 1'b1);

      // 3,9,1,7 then a long idle (hold behaviour on dut1).
      load4(3, 9, 1, 7);
      idle(14);
      chk("t1_n1", 8'(seen1), 8'd16);
      chk("t1_n2", 8'(seen2), 8'd4);
      chk("t1_count", 8'(nvalid), 8'd1);

      load4(15, 15, 15, 15);
      idle(5);
      chk("max_n1", 8'(seen1), 8'd30);
      chk("max_n2", 8'(seen2), 8'd30);
      load4(0, 0, 0, 0);
      idle(5);
      chk("zero_n1", 8'(seen1), 8'd0);
      chk("zero_n2", 8'(seen2), 8'd0);

      // Gap in the middle of a load.
      step(1'b1, 5, 1'b0);
      idle(3);
      step(1'b1, 2, 1'b0);
      step(1'b1, 8, 1'b0);
      step(1'b1, 5, 1'b0);
      idle(5);
      chk("gap_n1", 8'(seen1), 8'd13);
      chk("gap_n2", 8'(seen2), 8'd7);

      // Continuous in_valid: the 6s land during SORT/OUT and are dropped.
      load4(1, 2, 3, 4);
      load4(6, 6, 6, 6);
      chk("cont_n1", 8'(seen1), 8'd7);
      chk("cont_n2", 8'(seen2), 8'd3);
      load4(8, 1, 2, 3);
      idle(5);
      chk("b2b_n1", 8'(seen1), 8'd11);
      chk("b2b_n2", 8'(seen2), 8'd3);

      // Abort a partial load with reset.
      nvalid = 0;
      step(1'b1, 4, 1'b0);
      step(1'b1, 4, 1'b0);
      step(1'b1, 2, 1'b0);
      step(1'b1, 7, 1'b1);
      load4(1, 2, 3, 4);
      idle(5);
      chk("abort_count", 8'(nvalid), 8'd1);
      chk("abort_n1", 8'(seen1), 8'd7);
      chk("abort_n2", 8'(seen2), 8'd3);

      // Randomised traffic with occasional resets.
      for (int i = 0; i < 600; i++)
         step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
              int'($urandom_range(0, 15)),
              ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
      idle(6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rand_cmp_ctrl.md
RAND_CMP_CTRL -- requirements
Module: rand_cmp_ctrl

Interface
REQ-001 Parameter: HOLD_OUT, default 0, meaning 1 = outputs hold last result after out_valid falls and 0 = outputs return to 0.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 in_valid  input  1  high when in_number carries a number to load.
REQ-005 in_number  input  4  unsigned number, one per accepted cycle.
REQ-006 in_ready  output  1  high when a number is accepted on this edge if in_valid is high.
REQ-007 out_valid  output  1  one-cycle pulse marking a valid result.
REQ-008 out_number1  output  5  sum of the two largest of the four loaded numbers.
REQ-009 out_number2  output  5  sum of the two smallest of the four loaded numbers.

Function
REQ-010 The block SHALL use the states IDLE, LOAD, SORT and OUT.
REQ-011 in_ready SHALL be 1 in IDLE and LOAD, and 0 in SORT and OUT.
REQ-012 A number SHALL be accepted on an edge where in_valid and in_ready are both 1; it SHALL be written to slot cnt, and the 2-bit cnt SHALL increment.
REQ-013 IDLE->LOAD on acceptance of the first number, which goes to slot 0.
REQ-014 In LOAD, in_valid=0 SHALL hold cnt and slots, with no timeout.
REQ-015 LOAD->SORT on acceptance of the fourth number, into slot 3; cnt SHALL wrap to 0.
REQ-016 SORT SHALL last exactly 3 cycles and perform one compare-exchange stage per cycle:
  - stage 1 compares slots (0,1) and (2,3);
  - stage 2 compares slots (0,2) and (1,3);
  - stage 3 compares slots (1,2).
  In each compare-exchange, the larger value SHALL go to the lower-index slot.
REQ-017 On equal values, a compare-exchange SHALL NOT swap.
REQ-018 After stage 3, slot0 >= slot1 >= slot2 >= slot3 SHALL hold.
REQ-019 On the edge ending stage 3, the block SHALL register the following and enter OUT:
  - out_number1 = slot0 + slot1;
  - out_number2 = slot2 + slot3.
REQ-020 Both sums SHALL be computed in 5-bit unsigned arithmetic with no overflow; the maximum is 30.
REQ-021 In OUT, out_valid SHALL be 1 for exactly one cycle; the block SHALL then return to IDLE.
REQ-022 Latency: out_valid SHALL be high in the 4th cycle after the cycle in which the fourth number is accepted.
REQ-023 A new number SHALL be accepted no earlier than the cycle after the OUT cycle, i.e. when the block is back in IDLE.
REQ-024 in_valid during SORT or OUT SHALL be ignored; no slot, cnt or state change.
REQ-025 With HOLD_OUT=0, out_number1 and out_number2 SHALL be 0 whenever out_valid=0.
REQ-026 With HOLD_OUT=1, out_number1 and out_number2 SHALL keep the last result until the next OUT cycle.
REQ-027 Back-to-back operation: four numbers presented in the four cycles immediately after OUT SHALL be loaded without loss.

Reset
REQ-028 While rst=1 on an edge, the block SHALL set:
  - state = IDLE and cnt = 0;
  - all slots = 0;
  - out_valid = 0;
  - out_number1 = 0 and out_number2 = 0, for both HOLD_OUT values.
REQ-029 in_ready SHALL be 1 in the first cycle after reset is released.
REQ-030 Reset asserted during LOAD, SORT or OUT SHALL abort the operation:
  - partial loads SHALL be discarded;
  - no out_valid SHALL be produced for the aborted set.
REQ-031 A number presented with in_valid on a reset edge SHALL NOT be accepted.

Verification
REQ-032 Load 3,9,1,7 on consecutive cycles -> out_valid exactly 4 cycles after the 7 is accepted, out_number1=16, out_number2=4.
REQ-033 Load 15,15,15,15 -> out_number1=30, out_number2=30; load 0,0,0,0 -> 0, 0.
REQ-034 Load 5, then in_valid low 3 cycles, then 2,8,5 -> out_number1=13, out_number2=7; in_ready stays 1 during the gap.
REQ-035 Hold in_valid=1 continuously with values 1,2,3,4,6,6,6,6 -> the bench SHALL check:
  - the first result is 7, 3;
  - the values presented during SORT/OUT are dropped;
  - the next accepted set starts after OUT.
REQ-036 Load 4,4,2, then assert rst for 1 cycle, then load 1,2,3,4 -> the bench SHALL check:
  - no out_valid is produced for the aborted set;
  - the result is 7, 3.
REQ-037 With HOLD_OUT=1, run 3,9,1,7 and then idle 10 cycles -> out_number1/2 stay 16/4 while out_valid=0.
